r3_polymul_sched: RTL and testbench



---
 rtl/r3_polymul_sched.sv | 262 ++++++++++++++++++++++++++
 tb/tb_r3_polymul_sched.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r3_polymul_sched.sv
// r3_polymul_sched
// Computes the full (unreduced) product of two R3 polynomials of NB*32
// coefficients each by issuing all NB*NB 32x32 block products to a shared
// r3_mul_32 core and accumulating the 63-coefficient partial products mod 3.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   wr_en/wr_sel/wr_addr  operand word write (sel 0 = F, 1 = G), IDLE only
//   wr_d0/wr_d1           operand planes (d0 = nonzero, d1 = sign)
//   start                 begin a product (IDLE only)
//   busy/done             status; done is a one-cycle pulse
//   rd_addr/rd_d0/rd_d1   combinational result word read (0 beyond 2*NB-1)
//   mul_*                 handshake and operands to/from the multiplier core
//
// Coefficient encoding {d1,d0}: 0=(0,0), +1=(0,1)... i.e. d0=1,d1=0 is +1,
// d0=1,d1=1 is -1, d0=0 is 0 regardless of d1.
module r3_polymul_sched #(
   parameter int NB = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        wr_sel,
   input  logic [2:0]  wr_addr,
   input  logic [31:0] wr_d0,
   input  logic [31:0] wr_d1,
   input  logic        start,
   output logic        busy,
   output logic        done,
   input  logic [3:0]  rd_addr,
   output logic [31:0] rd_d0,
   output logic [31:0] rd_d1,
   output logic        mul_in_ready,
   output logic [31:0] mul_f0,
   output logic [31:0] mul_f1,
   output logic [31:0] mul_g0,
   output logic [31:0] mul_g1,
   input  logic [63:0] mul_do0,
   input  logic [63:0] mul_do1,
   input  logic        mul_valid
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_ACC   = 3'd3,
      S_DRAIN = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   // Map an encoded coefficient to 0, 1 or 2 (2 standing for -1).
   function automatic logic [1:0] coef_val(input logic d0, input logic d1);
      logic [1:0] v;
      if (!d0) begin
         v = 2'd0;
      end else if (d1) begin
         v = 2'd2;
      end else begin
         v = 2'd1;
      end
      return v;
   endfunction

   // Coefficient-wise mod-3 addition of two 32-coefficient words; returns {d1,d0}.
   function automatic logic [63:0] word_add(input logic [31:0] a0, input logic [31:0] a1,
                                            input logic [31:0] b0, input logic [31:0] b1);
      logic [31:0] r0;
      logic [31:0] r1;
      logic [2:0]  s;
      for (int n = 0; n < 32; n++) begin
         s = {1'b0, coef_val(a0[n], a1[n])} + {1'b0, coef_val(b0[n], b1[n])};
         if (s >= 3'd3) begin
            s = s - 3'd3;
         end else begin
            s = s;
         end
         r0[n] = (s != 3'd0);
         r1[n] = (s == 3'd2);
      end
      return {r1, r0};
   endfunction

   state_t      state_r, state_nx;
   logic [2:0]  i_r, j_r, i_nx, j_nx;
   logic [31:0] f0_r [0:7];
   logic [31:0] f1_r [0:7];
   logic [31:0] g0_r [0:7];
   logic [31:0] g1_r [0:7];
   logic [31:0] acc0_r [0:15];
   logic [31:0] acc1_r [0:15];
   logic [62:0] tile0_r, tile1_r;
   logic        busy_r, done_r, mul_in_ready_r;
   logic [31:0] mul_f0_r, mul_f1_r, mul_g0_r, mul_g1_r;
   logic [31:0] op_f0_s, op_f1_s, op_g0_s, op_g1_s;
   logic [3:0]  k_s, k1_s;
   logic [63:0] sum_lo_s, sum_hi_s;
   logic        wr_ok_s, last_s, rd_ok_s;
   logic        unused_s;

   // Bit 63 of the core outputs carries no coefficient.
   assign unused_s = mul_do0[63] ^ mul_do1[63];

   assign wr_ok_s = (state_r == S_IDLE) && wr_en && ({1'b0, wr_addr} < 4'(NB));
   assign last_s  = (i_r == 3'(NB - 1)) && (j_r == 3'(NB - 1));
   assign k_s     = {1'b0, i_r} + {1'b0, j_r};
   assign k1_s    = k_s + 4'd1;

   // State register and tile indices.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
         i_r     <= 3'd0;
         j_r     <= 3'd0;
      end else begin
         state_r <= state_nx;
         i_r     <= i_nx;
         j_r     <= j_nx;
      end
   end

   // Next-state logic; tiles are walked with i outer, j inner.
   always_comb begin
      state_nx = state_r;
      i_nx     = i_r;
      j_nx     = j_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_nx = S_ISSUE;
               i_nx     = 3'd0;
               j_nx     = 3'd0;
            end else begin
               state_nx = S_IDLE;
            end
         end
         S_ISSUE: state_nx = S_WAIT;
         S_WAIT: begin
            if (mul_valid) begin
               state_nx = S_ACC;
            end else begin
               state_nx = S_WAIT;
            end
         end
         S_ACC: state_nx = S_DRAIN;
         S_DRAIN: begin
            if (mul_valid) begin
               state_nx = S_DRAIN;
            end else if (last_s) begin
               state_nx = S_DONE;
            end else if (j_r == 3'(NB - 1)) begin
               state_nx = S_ISSUE;
               j_nx     = 3'd0;
               i_nx     = i_r + 3'd1;
            end else begin
               state_nx = S_ISSUE;
               j_nx     = j_r + 3'd1;
            end
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Operand words for the next issue; a write landing on the start cycle is
   // forwarded so the first tile already sees the new word.
   always_comb begin
      op_f0_s = f0_r[i_nx];
      op_f1_s = f1_r[i_nx];
      op_g0_s = g0_r[j_nx];
      op_g1_s = g1_r[j_nx];
      if (wr_ok_s && !wr_sel && (wr_addr == i_nx)) begin
         op_f0_s = wr_d0;
         op_f1_s = wr_d1;
      end else if (wr_ok_s && wr_sel && (wr_addr == j_nx)) begin
         op_g0_s = wr_d0;
         op_g1_s = wr_d1;
      end else begin
         op_f0_s = f0_r[i_nx];
         op_g0_s = g0_r[j_nx];
      end
   end

   // Mod-3 sums for the two result words touched by the current tile.
   always_comb begin
      sum_lo_s = word_add(acc0_r[k_s], acc1_r[k_s], tile0_r[31:0], tile1_r[31:0]);
      sum_hi_s = word_add(acc0_r[k1_s], acc1_r[k1_s], {1'b0, tile0_r[62:32]}, {1'b0, tile1_r[62:32]});
   end

   // Operand buffers, tile capture, accumulator and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int n = 0; n < 8; n++) begin
            f0_r[n] <= 32'd0;
            f1_r[n] <= 32'd0;
            g0_r[n] <= 32'd0;
            g1_r[n] <= 32'd0;
         end
         for (int n = 0; n < 16; n++) begin
            acc0_r[n] <= 32'd0;
            acc1_r[n] <= 32'd0;
         end
         tile0_r        <= 63'd0;
         tile1_r        <= 63'd0;
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
         mul_in_ready_r <= 1'b0;
         mul_f0_r       <= 32'd0;
         mul_f1_r       <= 32'd0;
         mul_g0_r       <= 32'd0;
         mul_g1_r       <= 32'd0;
      end else begin
         if (wr_ok_s) begin
            if (wr_sel) begin
               g0_r[wr_addr] <= wr_d0;
               g1_r[wr_addr] <= wr_d1;
            end else begin
               f0_r[wr_addr] <= wr_d0;
               f1_r[wr_addr] <= wr_d1;
            end
         end
         if ((state_r == S_IDLE) && start) begin
            for (int n = 0; n < 16; n++) begin
               acc0_r[n] <= 32'd0;
               acc1_r[n] <= 32'd0;
            end
         end else if (state_r == S_ACC) begin
            acc0_r[k_s]  <= sum_lo_s[31:0];
            acc1_r[k_s]  <= sum_lo_s[63:32];
            acc0_r[k1_s] <= sum_hi_s[31:0];
            acc1_r[k1_s] <= sum_hi_s[63:32];
         end
         if ((state_r == S_WAIT) && mul_valid) begin
            tile0_r <= mul_do0[62:0];
            tile1_r <= mul_do1[62:0];
         end
         if (state_nx == S_ISSUE) begin
            mul_f0_r <= op_f0_s;
            mul_f1_r <= op_f1_s;
            mul_g0_r <= op_g0_s;
            mul_g1_r <= op_g1_s;
         end
         mul_in_ready_r <= (state_nx == S_ISSUE);
         busy_r         <= (state_nx == S_ISSUE) || (state_nx == S_WAIT) ||
                           (state_nx == S_ACC)   || (state_nx == S_DRAIN);
         done_r         <= (state_nx == S_DONE);
      end
   end

   assign rd_ok_s = ({1'b0, rd_addr} < 5'(2 * NB));
   assign rd_d0   = rd_ok_s ? acc0_r[rd_addr] : 32'd0;
   assign rd_d1   = rd_ok_s ? acc1_r[rd_addr] : 32'd0;

   assign busy         = busy_r;
   assign done         = done_r;
   assign mul_in_ready = mul_in_ready_r;
   assign mul_f0       = mul_f0_r;
   assign mul_f1       = mul_f1_r;
   assign mul_g0       = mul_g0_r;
   assign mul_g1       = mul_g1_r;

endmodule

// File: tb/tb_r3_polymul_sched.sv
// Directed bench for r3_polymul_sched with a behavioural r3_mul_32 core model.
module tb_r3_polymul_sched;
   localparam int NB  = 4;
   localparam int LAT = 34;

   logic        clk = 1'b0;
   logic        rst, wr_en, wr_sel, start;
   logic [2:0]  wr_addr;
   logic [31:0] wr_d0, wr_d1;
   logic        busy, done;
   logic [3:0]  rd_addr;
   logic [31:0] rd_d0, rd_d1;
   logic        mul_in_ready;
   logic [31:0] mul_f0, mul_f1, mul_g0, mul_g1;
   logic [63:0] mul_do0, mul_do1;
   logic        mul_valid;

   logic        core_valid, extra_valid;
   logic [63:0] core_do0, core_do1;
   int          core_cnt;
   int          done_cnt = 0;
   int          n_checks = 0;
   int          n_pass   = 0;

   logic [31:0] fw0 [NB];
   logic [31:0] fw1 [NB];
   logic [31:0] gw0 [NB];
   logic [31:0] gw1 [NB];
   logic [31:0] ew0 [2*NB];
   logic [31:0] ew1 [2*NB];

   r3_polymul_sched #(.NB(NB)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
      .wr_d0(wr_d0), .wr_d1(wr_d1), .start(start), .busy(busy), .done(done),
      .rd_addr(rd_addr), .rd_d0(rd_d0), .rd_d1(rd_d1), .mul_in_ready(mul_in_ready),
      .mul_f0(mul_f0), .mul_f1(mul_f1), .mul_g0(mul_g0), .mul_g1(mul_g1),
      .mul_do0(mul_do0), .mul_do1(mul_do1), .mul_valid(mul_valid)
   );

   always #5 clk = ~clk;

   assign mul_valid = core_valid | extra_valid;
   assign mul_do0   = core_do0;
   assign mul_do1   = core_do1;

   // 32x32 block product mod 3; bit 63 is set as junk.
   function automatic logic [127:0] mul32(input logic [31:0] a0, input logic [31:0] a1,
                                          input logic [31:0] b0, input logic [31:0] b1);
      int c [63];
      int va, vb;
      logic [63:0] r0, r1;
      for (int n = 0; n < 63; n++) c[n] = 0;
      for (int a = 0; a < 32; a++) begin
         va = a0[a] ? (a1[a] ? 2 : 1) : 0;
         for (int b = 0; b < 32; b++) begin
            vb = b0[b] ? (b1[b] ? 2 : 1) : 0;
            c[a+b] = (c[a+b] + va * vb) % 3;
         end
      end
      r0 = 64'h8000_0000_0000_0000;
      r1 = 64'h8000_0000_0000_0000;
      for (int n = 0; n < 63; n++) begin
         r0[n] = (c[n] != 0);
         r1[n] = (c[n] == 2);
      end
      return {r1, r0};
   endfunction

   // Core model: product from the held operands, valid for two cycles after LAT.
   always @(posedge clk) begin
      if (rst) begin
         core_cnt   <= 0;
         core_valid <= 1'b0;
         core_do0   <= 64'd0;
         core_do1   <= 64'd0;
      end else begin
         if (mul_in_ready) core_cnt <= LAT;
         else if (core_cnt > 0) core_cnt <= core_cnt - 1;
         if (core_cnt == 2) {core_do1, core_do0} <= mul32(mul_f0, mul_f1, mul_g0, mul_g1);
         core_valid <= (core_cnt == 2) || (core_cnt == 1);
      end
   end

   always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic clear_ops();
      for (int w = 0; w < NB; w++) begin
         fw0[w] = 32'd0; fw1[w] = 32'd0; gw0[w] = 32'd0; gw1[w] = 32'd0;
      end
      for (int w = 0; w < 2*NB; w++) begin
         ew0[w] = 32'd0; ew1[w] = 32'd0;
      end
   endtask

   task automatic rand_ops();
      for (int w = 0; w < NB; w++) begin
         fw0[w] = $urandom; fw1[w] = $urandom & fw0[w];
         gw0[w] = $urandom; gw1[w] = $urandom & gw0[w];
      end
   endtask

   // Schoolbook mod-3 product of the whole polynomials into ew.
   task automatic model_ops();
      int c [2*NB*32];
      int va, vb;
      for (int n = 0; n < 2*NB*32; n++) c[n] = 0;
      for (int a = 0; a < NB*32; a++) begin
         va = fw0[a/32][a%32] ? (fw1[a/32][a%32] ? 2 : 1) : 0;
         for (int b = 0; b < NB*32; b++) begin
            vb = gw0[b/32][b%32] ? (gw1[b/32][b%32] ? 2 : 1) : 0;
            c[a+b] = (c[a+b] + va * vb) % 3;
         end
      end
      for (int n = 0; n < 2*NB*32; n++) begin
         ew0[n/32][n%32] = (c[n] != 0);
         ew1[n/32][n%32] = (c[n] == 2);
      end
   endtask

   task automatic write_word(input logic sel, input int addr, input logic [31:0] d0, input logic [31:0] d1);
      wr_en = 1'b1; wr_sel = sel; wr_addr = 3'(addr); wr_d0 = d0; wr_d1 = d1;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic load_ops();
      for (int w = 0; w < NB; w++) begin
         write_word(1'b0, w, fw0[w], fw1[w]);
         write_word(1'b1, w, gw0[w], gw1[w]);
      end
   endtask

   task automatic run_product(input bit wr_on_start, input logic [31:0] wd0, input logic [31:0] wd1, input bit poke);
      int cyc;
      int dc;
      dc = done_cnt;
      if (wr_on_start) begin
         wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 3'd0; wr_d0 = wd0; wr_d1 = wd1;
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0; cyc = 1;
      check("busy_after_start", 64'(busy), 64'd1);
      while (done !== 1'b1 && cyc < 800) begin
         if (poke && cyc == 100) begin
            start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 3'd0;
            wr_d0 = 32'hFFFF_FFFF; wr_d1 = 32'h0;
         end else begin
            start = 1'b0; wr_en = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0; wr_en = 1'b0;
      check("done_seen", 64'(done), 64'd1);
      check("busy_at_done", 64'(busy), 64'd0);
      check("latency_ok", 64'(cyc <= NB*NB*42+4), 64'd1);
      @(negedge clk);
      check("done_one_cycle", 64'(done), 64'd0);
      check("done_count", 64'(done_cnt - dc), 64'd1);
   endtask

   task automatic check_result(input string tag);
      for (int w = 0; w < 2*NB; w++) begin
         rd_addr = 4'(w);
         #1;
         check($sformatf("%s_w%0d", tag, w), {rd_d1, rd_d0}, {ew1[w], ew0[w]});
         @(negedge clk);
      end
      rd_addr = 4'(2*NB);
      #1;
      check($sformatf("%s_oob", tag), {rd_d1, rd_d0}, 64'd0);
      @(negedge clk);
      rd_addr = 4'd15;
      #1;
      check($sformatf("%s_oob15", tag), {rd_d1, rd_d0}, 64'd0);
      @(negedge clk);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int npulse;
      int cyc;
      int dc;
      rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 3'd0; wr_d0 = 32'd0; wr_d1 = 32'd0;
      start = 1'b0; rd_addr = 4'd0; extra_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_in_ready", 64'(mul_in_ready), 64'd0);
      check("rst_mul_ops", {mul_f0 | mul_f1, mul_g0 | mul_g1}, 64'd0);
      clear_ops();
      check_result("rst_acc");
      rst = 1'b0;
      @(negedge clk);

      // F = 1: result low words equal G, high words zero.
      clear_ops();
      rand_ops();
      for (int w = 0; w < NB; w++) begin fw0[w] = 32'd0; fw1[w] = 32'd0; end
      fw0[0] = 32'd1;
      for (int w = 0; w < NB; w++) begin ew0[w] = gw0[w]; ew1[w] = gw1[w]; end
      for (int w = NB; w < 2*NB; w++) begin ew0[w] = 32'd0; ew1[w] = 32'd0; end
      load_ops();
      run_product(1'b0, 32'd0, 32'd0, 1'b0);
      check_result("f_one");

      // Same, but F word 0 is written in the start cycle (old value zero).
      write_word(1'b0, 0, 32'd0, 32'd0);
      run_product(1'b1, 32'd1, 32'd0, 1'b0);
      check_result("wr_on_start");

      // (+x^31)(-x^31) = -x^62: word1 bit30 both planes.
      clear_ops();
      fw0[0] = 32'h8000_0000;
      gw0[0] = 32'h8000_0000; gw1[0] = 32'h8000_0000;
      ew0[1] = 32'h4000_0000; ew1[1] = 32'h4000_0000;
      load_ops();
      run_product(1'b0, 32'd0, 32'd0, 1'b0);
      check_result("c62");

      // x^32 * x^40 = x^72: word2 bit8.
      clear_ops();
      fw0[1] = 32'h0000_0001;
      gw0[1] = 32'h0000_0100;
      ew0[2] = 32'h0000_0100;
      load_ops();
      run_product(1'b0, 32'd0, 32'd0, 1'b0);
      check_result("c72");

      // (1+x^32)^2 = 1 + 2x^32 + x^64 = 1 - x^32 + x^64.
      clear_ops();
      fw0[0] = 32'd1; fw0[1] = 32'd1;
      gw0[0] = 32'd1; gw0[1] = 32'd1;
      ew0[0] = 32'd1;
      ew0[1] = 32'd1; ew1[1] = 32'd1;
      ew0[2] = 32'd1;
      load_ops();
      run_product(1'b0, 32'd0, 32'd0, 1'b0);
      check_result("cross");

      // (-1)(-1) = +1.
      clear_ops();
      fw0[0] = 32'd1; fw1[0] = 32'd1;
      gw0[0] = 32'd1; gw1[0] = 32'd1;
      ew0[0] = 32'd1;
      load_ops();
      run_product(1'b0, 32'd0, 32'd0, 1'b0);
      check_result("negneg");

      // Random operands against the schoolbook model.
      for (int r = 0; r < 12; r++) begin
         rand_ops();
         model_ops();
         load_ops();
         run_product(1'b0, 32'd0, 32'd0, 1'b0);
         check_result($sformatf("rand%0d", r));
      end

      // start and wr_en during busy are ignored; rerun proves F[0] untouched.
      rand_ops();
      model_ops();
      load_ops();
      run_product(1'b0, 32'd0, 32'd0, 1'b1);
      check_result("poke");
      run_product(1'b0, 32'd0, 32'd0, 1'b0);
      check_result("poke_rerun");

      // Spurious valid while idle changes nothing.
      extra_valid = 1'b1;
      repeat (3) @(negedge clk);
      extra_valid = 1'b0;
      check("idle_valid_busy", 64'(busy), 64'd0);
      check_result("idle_valid");

      // Reset during the fifth tile.
      rand_ops();
      load_ops();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      npulse = 0; cyc = 0;
      while (npulse < 5 && cyc < 1000) begin
         if (mul_in_ready === 1'b1) npulse++;
         @(negedge clk);
         cyc++;
      end
      check("tile5_reached", 64'(npulse), 64'd5);
      repeat (10) @(negedge clk);
      dc = done_cnt;
      rst = 1'b1;
      @(negedge clk);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_done", 64'(done), 64'd0);
      check("midrst_in_ready", 64'(mul_in_ready), 64'd0);
      rst = 1'b0;
      repeat (50) @(negedge clk);
      check("midrst_no_done", 64'(done_cnt - dc), 64'd0);
      for (int w = 0; w < 2*NB; w++) begin ew0[w] = 32'd0; ew1[w] = 32'd0; end
      check_result("midrst_acc");
      model_ops();
      load_ops();
      run_product(1'b0, 32'd0, 32'd0, 1'b0);
      check_result("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
